// File: rtl/bin_to_bcd_seq.sv
// Sequential 16-bit binary to 4-digit BCD converter (double dabble, one bit per cycle).
// Results above 9999 either saturate or wrap, selected by SAT_EN; ovf flags the over-range case.
module bin_to_bcd_seq #(
  parameter bit SAT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] bin_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd_out,
  output logic        ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q;
  logic [15:0] shift_q;
  logic [19:0] acc_q;
  logic [4:0]  cnt_q;
  logic        busy_q;
  logic        done_q;
  logic [15:0] bcd_q;
  logic        ovf_q;

  logic [19:0] acc_adj_d;
  logic [36:0] wide_d;
  logic [19:0] acc_d;
  logic [15:0] shift_d;
  logic        ovf_d;
  logic [15:0] bcd_d;

  function automatic logic [3:0] digit_adj(input logic [3:0] d);
    if (d >= 4'd5) begin
      return d + 4'd3;
    end else begin
      return d;
    end
  endfunction

  // One double-dabble step; the result is also decoded so outputs load on the final step.
  always_comb begin
    acc_adj_d = 20'h00000;
    for (int i = 0; i < 5; i++) begin
      acc_adj_d[i*4 +: 4] = digit_adj(acc_q[i*4 +: 4]);
    end
    wide_d  = {acc_adj_d, shift_q, 1'b0};
    acc_d   = wide_d[35:16];
    shift_d = wide_d[15:0];
    ovf_d   = |wide_d[36:32];
    if (ovf_d && SAT_EN) begin
      bcd_d = 16'h9999;
    end else begin
      bcd_d = acc_d[15:0];
    end
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= 16'h0000;
      acc_q   <= 20'h00000;
      cnt_q   <= 5'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= 16'h0000;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            shift_q <= bin_in;
            acc_q   <= 20'h00000;
            cnt_q   <= 5'd0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          acc_q   <= acc_d;
          shift_q <= shift_d;
          cnt_q   <= cnt_q + 5'd1;
          if (cnt_q == 5'd15) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_out = bcd_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: saturating and wrapping instances share the stimulus,
// expected results come from decimal arithmetic, timing from the accept/busy/done cycle rules.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] bin_in;

  logic        busy_s, done_s, ovf_s;
  logic [15:0] bcd_s;
  logic        busy_m, done_m, ovf_m;
  logic [15:0] bcd_m;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.SAT_EN(1'b1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
    .busy(busy_s), .done(done_s), .bcd_out(bcd_s), .ovf(ovf_s)
  );

  bin_to_bcd_seq #(.SAT_EN(1'b0)) dut_mod (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
    .busy(busy_m), .done(done_m), .bcd_out(bcd_m), .ovf(ovf_m)
  );

  typedef struct packed {
    logic [15:0] sat;
    logic [15:0] md;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;
  int   acc_edge = 0;
  bit   active = 1'b0;

  logic [15:0] held_s = 16'h0000;
  logic [15:0] held_m = 16'h0000;
  logic        held_o = 1'b0;

  function automatic logic [15:0] dec4(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic exp_t make_exp(input logic [15:0] b);
    exp_t e;
    int   v;
    v     = int'({16'h0000, b});
    e.ovf = (v > 9999);
    e.sat = (v > 9999) ? 16'h9999 : dec4(v);
    e.md  = dec4(v % 10000);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h at edge %0d", name, got, want, edge_cnt);
    end
  endtask

  // Reference side: decides which starts are accepted and queues their results.
  always @(posedge clk) begin
    edge_cnt++;
    if (!rst_n) begin
      active = 1'b0;
      exp_q.delete();
    end else if (start && (!active || (edge_cnt - acc_edge) >= 18)) begin
      active   = 1'b1;
      acc_edge = edge_cnt;
      exp_q.push_back(make_exp(bin_in));
    end
  end

  // Monitor: checks handshake timing every cycle and pops results on done.
  always @(posedge clk) begin
    bit   exp_busy;
    bit   exp_done;
    exp_t e;
    #1;
    exp_busy = active && ((edge_cnt - acc_edge) <= 16);
    exp_done = active && ((edge_cnt - acc_edge) == 16);
    if (!rst_n) begin
      held_s = 16'h0000;
      held_m = 16'h0000;
      held_o = 1'b0;
    end
    check("busy_sat", {31'd0, busy_s}, {31'd0, exp_busy});
    check("busy_mod", {31'd0, busy_m}, {31'd0, exp_busy});
    check("done_sat", {31'd0, done_s}, {31'd0, exp_done});
    check("done_mod", {31'd0, done_m}, {31'd0, exp_done});
    if (done_s === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL spurious_done got pulse want none at edge %0d", edge_cnt);
      end else begin
        e = exp_q.pop_front();
        check("bcd_sat", {16'd0, bcd_s}, {16'd0, e.sat});
        check("bcd_mod", {16'd0, bcd_m}, {16'd0, e.md});
        check("ovf_sat", {31'd0, ovf_s}, {31'd0, e.ovf});
        check("ovf_mod", {31'd0, ovf_m}, {31'd0, e.ovf});
        held_s = e.sat;
        held_m = e.md;
        held_o = e.ovf;
      end
    end else begin
      check("hold_bcd_sat", {16'd0, bcd_s}, {16'd0, held_s});
      check("hold_bcd_mod", {16'd0, bcd_m}, {16'd0, held_m});
      check("hold_ovf", {30'd0, ovf_s, ovf_m}, {30'd0, held_o, held_o});
    end
  end

  task automatic issue(input logic [15:0] v);
    start  = 1'b1;
    bin_in = v;
    @(negedge clk);
    start  = 1'b0;
    bin_in = 16'($urandom);
    repeat (19) @(negedge clk);
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b1;
    bin_in = 16'h1111;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    issue(16'h0000);
    issue(16'h04D2);
    issue(16'h270F);
    issue(16'h2710);
    issue(16'hFFFF);
    issue(16'h0001);
    issue(16'h0009);
    issue(16'h000A);

    // start held high across a whole conversion; operand changes mid-conversion
    start  = 1'b1;
    bin_in = 16'd42;
    repeat (5) @(negedge clk);
    bin_in = 16'd7;
    repeat (14) @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);

    // reset in the middle of a conversion, then a fresh conversion
    start  = 1'b1;
    bin_in = 16'd1234;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    issue(16'd5678);

    // randomized traffic with occasional resets
    repeat (600) begin
      start  = ($urandom_range(0, 3) == 0);
      bin_in = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 9999)) : 16'($urandom);
      rst_n  = ($urandom_range(0, 199) != 0);
      @(negedge clk);
    end
    rst_n = 1'b1;
    start = 1'b0;
    repeat (20) @(negedge clk);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_results got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
